// File: rtl/regfile_ckpt.sv
// Register file with rename tags and a FIFO of rename-table checkpoints.
// Optional build macro REGFILE_BYPASS_EN forwards same-cycle rename/commit to the read ports.
module regfile_ckpt #(
  parameter int XLEN       = 32,
  parameter int REG_BIT    = 5,
  parameter int ROB_BIT    = 4,
  parameter int NUM_RD     = 2,
  parameter int CKPT_DEPTH = 4
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic                        rdy,
  input  logic                        reg_en,
  input  logic                        reg_st,
  input  logic                        reg_rb,
  input  logic [NUM_RD*REG_BIT-1:0]   rd_rs,
  output logic [NUM_RD*ROB_BIT-1:0]   rd_src,
  output logic [NUM_RD*XLEN-1:0]      rd_val,
  input  logic                        rn_ena,
  input  logic [REG_BIT-1:0]          rn_rd,
  input  logic [ROB_BIT-1:0]          rn_idx,
  input  logic                        cm_ena,
  input  logic [REG_BIT-1:0]          cm_rd,
  input  logic [ROB_BIT-1:0]          cm_idx,
  input  logic [XLEN-1:0]             cm_val,
  input  logic                        ck_save,
  output logic [$clog2(CKPT_DEPTH)-1:0] ck_id,
  output logic                        ck_ok,
  input  logic                        ck_free,
  input  logic                        ck_restore,
  input  logic [$clog2(CKPT_DEPTH)-1:0] ck_rid,
  output logic                        ck_full,
  output logic                        ck_empty
);

  localparam int NREG = 1 << REG_BIT;
  localparam int CW   = $clog2(CKPT_DEPTH);
  localparam logic [CW:0] FULL_CNT = (CW+1)'(CKPT_DEPTH);

  logic [ROB_BIT-1:0] src_q  [NREG];
  logic [ROB_BIT-1:0] src_d  [NREG];
  logic [XLEN-1:0]    val_q  [NREG];
  logic [XLEN-1:0]    val_d  [NREG];
  logic [ROB_BIT-1:0] snap_q [CKPT_DEPTH][NREG];
  logic [ROB_BIT-1:0] snap_d [CKPT_DEPTH][NREG];
  logic [CW-1:0]      head_q, head_d, tail_q, tail_d;
  logic [CW:0]        count_q, count_d;

  logic          upd, flush, rst_acc, free_acc, save_acc, rn_eff, cm_eff, cm_val_wr;
  logic [CW-1:0] rid_age;

  assign upd       = rst_n & rdy & reg_en & ~reg_st & ~reg_rb;
  assign flush     = rst_n & rdy & reg_rb;
  // A slot is live when its distance from head is below the current count.
  assign rid_age   = ck_rid - head_q;
  assign rst_acc   = upd & ck_restore & ({1'b0, rid_age} < count_q);
  assign free_acc  = upd & ck_free & (count_q != '0) & ~rst_acc;
  // ck_save is a request; ck_ok is its same-cycle grant and ck_id names the slot written.
  assign save_acc  = upd & ck_save & (~ck_full | free_acc) & ~rst_acc;
  assign rn_eff    = upd & rn_ena & (rn_rd != '0) & ~rst_acc;
  assign cm_eff    = upd & cm_ena & (cm_rd != '0);
  assign cm_val_wr = (upd | flush) & cm_ena & (cm_rd != '0);

  assign ck_full  = (count_q == FULL_CNT);
  assign ck_empty = (count_q == '0);
  assign ck_ok    = save_acc;
  assign ck_id    = tail_q;

  always_comb begin
    src_d   = src_q;
    val_d   = val_q;
    snap_d  = snap_q;
    head_d  = head_q;
    tail_d  = tail_q;
    count_d = count_q;
    if (cm_val_wr) val_d[cm_rd] = cm_val;
    if (flush) begin
      for (int r = 0; r < NREG; r++) src_d[r] = '0;
      head_d  = '0;
      tail_d  = '0;
      count_d = '0;
    end else if (upd) begin
      if (rst_acc) begin
        src_d   = snap_q[ck_rid];
        tail_d  = ck_rid;
        count_d = {1'b0, rid_age};
      end
      // Commit clears a matching tag in the working table and every snapshot.
      if (cm_eff) begin
        if (src_d[cm_rd] == cm_idx) src_d[cm_rd] = '0;
        for (int s = 0; s < CKPT_DEPTH; s++)
          if (snap_d[s][cm_rd] == cm_idx) snap_d[s][cm_rd] = '0;
      end
      if (rn_eff) src_d[rn_rd] = rn_idx;
      if (save_acc) begin
        snap_d[tail_q] = src_d;
        tail_d         = tail_q + 1'b1;
      end
      if (free_acc) head_d = head_q + 1'b1;
      if (!rst_acc) count_d = count_q + (CW+1)'(save_acc) - (CW+1)'(free_acc);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int r = 0; r < NREG; r++) begin
        src_q[r] <= '0;
        val_q[r] <= '0;
        for (int s = 0; s < CKPT_DEPTH; s++) snap_q[s][r] <= '0;
      end
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
    end else begin
      src_q   <= src_d;
      val_q   <= val_d;
      snap_q  <= snap_d;
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
    end
  end

  always_comb begin
    rd_src = '0;
    rd_val = '0;
    for (int p = 0; p < NUM_RD; p++) begin
      logic [REG_BIT-1:0] rs;
      logic [ROB_BIT-1:0] tag;
      logic [XLEN-1:0]    v;
      rs  = rd_rs[p*REG_BIT +: REG_BIT];
      tag = src_q[rs];
      v   = val_q[rs];
`ifdef REGFILE_BYPASS_EN
      if (rn_eff && (rn_rd == rs)) begin
        tag = rn_idx;
      end else if (cm_eff && (cm_rd == rs) && (src_q[rs] == cm_idx)) begin
        tag = '0;
        v   = cm_val;
      end
`endif
      if (rs == '0) begin
        tag = '0;
        v   = '0;
      end
      rd_src[p*ROB_BIT +: ROB_BIT] = tag;
      rd_val[p*XLEN +: XLEN]       = v;
    end
  end

endmodule

// File: tb/tb_regfile_ckpt.sv
// Bench for regfile_ckpt: directed vector table, hand sequences, then random traffic
// checked against a queue-based model of the register file and snapshot FIFO.
module tb_regfile_ckpt;

  logic        clk, rst_n, rdy, reg_en, reg_st, reg_rb;
  logic [9:0]  rd_rs;
  logic [7:0]  rd_src;
  logic [63:0] rd_val;
  logic        rn_ena, cm_ena, ck_save, ck_ok, ck_free, ck_restore, ck_full, ck_empty;
  logic [4:0]  rn_rd, cm_rd;
  logic [3:0]  rn_idx, cm_idx;
  logic [31:0] cm_val;
  logic [1:0]  ck_id, ck_rid;

  int checks = 0;
  int errors = 0;

  regfile_ckpt dut (
    .clk(clk), .rst_n(rst_n), .rdy(rdy), .reg_en(reg_en), .reg_st(reg_st), .reg_rb(reg_rb),
    .rd_rs(rd_rs), .rd_src(rd_src), .rd_val(rd_val),
    .rn_ena(rn_ena), .rn_rd(rn_rd), .rn_idx(rn_idx),
    .cm_ena(cm_ena), .cm_rd(cm_rd), .cm_idx(cm_idx), .cm_val(cm_val),
    .ck_save(ck_save), .ck_id(ck_id), .ck_ok(ck_ok), .ck_free(ck_free),
    .ck_restore(ck_restore), .ck_rid(ck_rid), .ck_full(ck_full), .ck_empty(ck_empty)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic rdy, en, st, rb;
    logic rn; logic [4:0] rn_rd; logic [3:0] rn_idx;
    logic cm; logic [4:0] cm_rd; logic [3:0] cm_idx; logic [31:0] cm_val;
    logic sv, fr, rs; logic [1:0] rid;
    logic [4:0] r0, r1;
    logic e_ok; logic [1:0] e_id;
    logic [3:0] e_s0; logic [31:0] e_v0; logic [3:0] e_s1; logic [31:0] e_v1;
    logic e_full, e_empty;
  } vec_t;

  vec_t vq[$];

  // reference model
  typedef struct packed { logic [1:0] id; logic [127:0] t; } snap_t;
  snap_t       snap_m[$];
  logic [3:0]  src_m[32];
  logic [31:0] val_m[32];
  logic [1:0]  tail_m;

  logic        s_rdy, s_en, s_st, s_rb, s_rn, s_cm, s_sv, s_fr, s_rs;
  logic [4:0]  s_rn_rd, s_cm_rd;
  logic [3:0]  s_rn_idx, s_cm_idx;
  logic [31:0] s_cm_val;
  logic [1:0]  s_rid;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic model_reset();
    for (int r = 0; r < 32; r++) begin
      src_m[r] = '0;
      val_m[r] = '0;
    end
    snap_m.delete();
    tail_m = '0;
  endtask

  task automatic model_step(output logic ok);
    logic  upd, flsh, free_ok;
    int    pos, n0;
    snap_t s;
    ok   = 1'b0;
    upd  = s_rdy && s_en && !s_st && !s_rb;
    flsh = s_rdy && s_rb;
    n0   = snap_m.size();
    if (flsh) begin
      for (int r = 0; r < 32; r++) src_m[r] = '0;
      snap_m.delete();
      tail_m = '0;
      if (s_cm && s_cm_rd != 0) val_m[s_cm_rd] = s_cm_val;
    end else if (upd) begin
      pos = -1;
      if (s_rs) for (int i = 0; i < n0; i++) if (snap_m[i].id == s_rid) pos = i;
      if (pos >= 0) begin
        s = snap_m[pos];
        for (int r = 0; r < 32; r++) src_m[r] = s.t[r*4 +: 4];
        while (snap_m.size() > pos) s = snap_m.pop_back();
        tail_m = s_rid;
      end
      free_ok = s_fr && (n0 > 0) && (pos < 0);
      if (s_cm && s_cm_rd != 0) begin
        val_m[s_cm_rd] = s_cm_val;
        if (src_m[s_cm_rd] == s_cm_idx) src_m[s_cm_rd] = '0;
        for (int i = 0; i < snap_m.size(); i++) begin
          s = snap_m[i];
          if (s.t[s_cm_rd*4 +: 4] == s_cm_idx) s.t[s_cm_rd*4 +: 4] = '0;
          snap_m[i] = s;
        end
      end
      if (pos < 0 && s_rn && s_rn_rd != 0) src_m[s_rn_rd] = s_rn_idx;
      ok = s_sv && (pos < 0) && ((n0 < 4) || free_ok);
      if (free_ok) s = snap_m.pop_front();
      if (ok) begin
        s.id = tail_m;
        for (int r = 0; r < 32; r++) s.t[r*4 +: 4] = src_m[r];
        snap_m.push_back(s);
        tail_m = tail_m + 2'd1;
      end
    end
  endtask

  // driver tasks
  task automatic idle_inputs();
    rdy = 1; reg_en = 1; reg_st = 0; reg_rb = 0;
    rn_ena = 0; rn_rd = 0; rn_idx = 0;
    cm_ena = 0; cm_rd = 0; cm_idx = 0; cm_val = 0;
    ck_save = 0; ck_free = 0; ck_restore = 0; ck_rid = 0;
  endtask

  task automatic drive_stim();
    rdy = s_rdy; reg_en = s_en; reg_st = s_st; reg_rb = s_rb;
    rn_ena = s_rn; rn_rd = s_rn_rd; rn_idx = s_rn_idx;
    cm_ena = s_cm; cm_rd = s_cm_rd; cm_idx = s_cm_idx; cm_val = s_cm_val;
    ck_save = s_sv; ck_free = s_fr; ck_restore = s_rs; ck_rid = s_rid;
  endtask

  task automatic do_reset();
    idle_inputs();
    rd_rs = '0;
    rst_n = 0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1;
  endtask

  task automatic apply_vec(input vec_t v);
    @(negedge clk);
    s_rdy = v.rdy; s_en = v.en; s_st = v.st; s_rb = v.rb;
    s_rn = v.rn; s_rn_rd = v.rn_rd; s_rn_idx = v.rn_idx;
    s_cm = v.cm; s_cm_rd = v.cm_rd; s_cm_idx = v.cm_idx; s_cm_val = v.cm_val;
    s_sv = v.sv; s_fr = v.fr; s_rs = v.rs; s_rid = v.rid;
    drive_stim();
    #1;
    chk("vec_ck_ok", 32'(ck_ok), 32'(v.e_ok));
    if (v.e_ok) chk("vec_ck_id", 32'(ck_id), 32'(v.e_id));
    @(posedge clk);
    #1;
    idle_inputs();
    rd_rs = {v.r1, v.r0};
    #1;
    chk("vec_src0", 32'(rd_src[3:0]), 32'(v.e_s0));
    chk("vec_val0", rd_val[31:0], v.e_v0);
    chk("vec_src1", 32'(rd_src[7:4]), 32'(v.e_s1));
    chk("vec_val1", rd_val[63:32], v.e_v1);
    chk("vec_full", 32'(ck_full), 32'(v.e_full));
    chk("vec_empty", 32'(ck_empty), 32'(v.e_empty));
  endtask

  task automatic rand_step();
    logic exp_ok;
    logic [1:0] exp_id;
    logic [4:0] r0, r1;
    @(negedge clk);
    s_rdy = ($urandom_range(0, 9) != 0);
    s_en  = ($urandom_range(0, 9) != 0);
    s_st  = ($urandom_range(0, 9) == 0);
    s_rb  = ($urandom_range(0, 39) == 0);
    s_rn  = $urandom_range(0, 1);
    s_rn_rd  = ($urandom_range(0, 3) == 0) ? 5'($urandom_range(0, 31)) : 5'($urandom_range(0, 7));
    s_rn_idx = 4'($urandom_range(0, 15));
    s_cm  = $urandom_range(0, 1);
    s_cm_rd  = 5'($urandom_range(0, 7));
    s_cm_idx = $urandom_range(0, 1) ? src_m[s_cm_rd] : 4'($urandom_range(0, 15));
    s_cm_val = $urandom;
    s_sv  = ($urandom_range(0, 2) == 0);
    s_fr  = ($urandom_range(0, 3) == 0);
    s_rs  = ($urandom_range(0, 9) == 0);
    s_rid = 2'($urandom_range(0, 3));
    drive_stim();
    exp_id = tail_m;
    model_step(exp_ok);
    #1;
    chk("rnd_ck_ok", 32'(ck_ok), 32'(exp_ok));
    if (exp_ok) chk("rnd_ck_id", 32'(ck_id), 32'(exp_id));
    @(posedge clk);
    #1;
    idle_inputs();
    r0 = 5'($urandom_range(0, 7));
    r1 = 5'($urandom_range(0, 31));
    rd_rs = {r1, r0};
    #1;
    chk("rnd_src0", 32'(rd_src[3:0]), 32'(src_m[r0]));
    chk("rnd_val0", rd_val[31:0], val_m[r0]);
    chk("rnd_src1", 32'(rd_src[7:4]), 32'(src_m[r1]));
    chk("rnd_val1", rd_val[63:32], val_m[r1]);
    chk("rnd_full", 32'(ck_full), 32'(snap_m.size() == 4));
    chk("rnd_empty", 32'(ck_empty), 32'(snap_m.size() == 0));
  endtask

  initial begin
    // rdy en st rb | rn rd idx | cm rd idx val | sv fr rs rid | r0 r1 | ok id | s0 v0 s1 v1 | full empty
    vq.push_back(vec_t'{1,1,0,0, 0,0,0, 0,0,0,0,        0,0,0,0, 5,5, 0,0, 0,0,0,0,              0,1});
    vq.push_back(vec_t'{1,1,0,0, 1,5,3, 0,0,0,0,        0,0,0,0, 5,5, 0,0, 3,0,3,0,              0,1});
    vq.push_back(vec_t'{1,1,0,0, 0,0,0, 1,5,2,'hAAAA,   0,0,0,0, 5,5, 0,0, 3,'hAAAA,3,'hAAAA,    0,1});
    vq.push_back(vec_t'{1,1,0,0, 0,0,0, 1,5,3,'h1234,   0,0,0,0, 5,5, 0,0, 0,'h1234,0,'h1234,    0,1});
    vq.push_back(vec_t'{1,1,0,0, 1,7,4, 0,0,0,0,        0,0,0,0, 7,5, 0,0, 4,0,0,'h1234,         0,1});
    vq.push_back(vec_t'{1,1,0,0, 0,0,0, 0,0,0,0,        1,0,0,0, 7,5, 1,0, 4,0,0,'h1234,         0,0});
    vq.push_back(vec_t'{1,1,0,0, 1,7,6, 0,0,0,0,        0,0,0,0, 7,5, 0,0, 6,0,0,'h1234,         0,0});
    vq.push_back(vec_t'{1,1,0,0, 0,0,0, 0,0,0,0,        0,0,1,0, 7,5, 0,0, 4,0,0,'h1234,         0,1});
    vq.push_back(vec_t'{1,1,0,0, 1,9,5, 0,0,0,0,        0,0,0,0, 9,7, 0,0, 5,0,4,0,              0,1});
    vq.push_back(vec_t'{1,1,0,0, 0,0,0, 0,0,0,0,        1,0,0,0, 9,7, 1,0, 5,0,4,0,              0,0});
    vq.push_back(vec_t'{1,1,0,0, 0,0,0, 1,9,5,'h99,     0,0,0,0, 9,7, 0,0, 0,'h99,4,0,           0,0});
    vq.push_back(vec_t'{1,1,0,0, 1,9,7, 0,0,0,0,        0,0,0,0, 9,7, 0,0, 7,'h99,4,0,           0,0});
    vq.push_back(vec_t'{1,1,0,0, 0,0,0, 0,0,0,0,        0,0,1,0, 9,7, 0,0, 0,'h99,4,0,           0,1});
    vq.push_back(vec_t'{1,1,0,0, 0,0,0, 0,0,0,0,        1,0,0,0, 9,7, 1,0, 0,'h99,4,0,           0,0});
    vq.push_back(vec_t'{1,1,0,0, 0,0,0, 0,0,0,0,        1,0,0,0, 9,7, 1,1, 0,'h99,4,0,           0,0});
    vq.push_back(vec_t'{1,1,0,0, 0,0,0, 0,0,0,0,        1,0,0,0, 9,7, 1,2, 0,'h99,4,0,           0,0});
    vq.push_back(vec_t'{1,1,0,0, 0,0,0, 0,0,0,0,        1,0,0,0, 9,7, 1,3, 0,'h99,4,0,           1,0});
    vq.push_back(vec_t'{1,1,0,0, 0,0,0, 0,0,0,0,        1,0,0,0, 9,7, 0,0, 0,'h99,4,0,           1,0});
    vq.push_back(vec_t'{1,1,0,0, 0,0,0, 0,0,0,0,        1,1,0,0, 9,7, 1,0, 0,'h99,4,0,           1,0});
    vq.push_back(vec_t'{1,1,0,0, 0,0,0, 0,0,0,0,        0,1,0,0, 9,7, 0,0, 0,'h99,4,0,           0,0});
    vq.push_back(vec_t'{1,1,0,0, 1,0,9, 1,0,0,'hFFFF,   0,0,0,0, 0,0, 0,0, 0,0,0,0,              0,0});
    vq.push_back(vec_t'{1,1,0,0, 1,5,8, 0,0,0,0,        0,0,0,0, 5,0, 0,0, 8,'h1234,0,0,         0,0});
    vq.push_back(vec_t'{1,1,0,1, 1,5,2, 1,5,1,'h5555,   0,0,0,0, 5,7, 0,0, 0,'h5555,0,0,         0,1});
    vq.push_back(vec_t'{1,1,0,0, 0,0,0, 0,0,0,0,        0,1,0,0, 5,9, 0,0, 0,'h5555,0,'h99,      0,1});
    vq.push_back(vec_t'{1,1,0,0, 0,0,0, 0,0,0,0,        1,0,0,0, 5,9, 1,0, 0,'h5555,0,'h99,      0,0});
    vq.push_back(vec_t'{1,1,0,0, 1,5,3, 0,0,0,0,        0,0,1,2, 5,9, 0,0, 3,'h5555,0,'h99,      0,0});
    vq.push_back(vec_t'{1,1,1,0, 1,5,9, 0,0,0,0,        0,0,0,0, 5,9, 0,0, 3,'h5555,0,'h99,      0,0});
    vq.push_back(vec_t'{0,1,0,1, 0,0,0, 0,0,0,0,        0,0,0,0, 5,9, 0,0, 3,'h5555,0,'h99,      0,0});
    vq.push_back(vec_t'{1,0,0,0, 0,0,0, 1,5,3,'h7777,   0,0,0,0, 5,9, 0,0, 3,'h5555,0,'h99,      0,0});

    do_reset();
    #1;
    chk("reset_empty", 32'(ck_empty), 32'd1);
    chk("reset_full", 32'(ck_full), 32'd0);
    chk("reset_ck_id", 32'(ck_id), 32'd0);
    foreach (vq[i]) apply_vec(vq[i]);

`ifdef REGFILE_BYPASS_EN
    @(negedge clk);
    idle_inputs();
    rn_ena = 1; rn_rd = 3; rn_idx = 2;
    rd_rs = {5'd3, 5'd0};
    #1;
    chk("bypass_rename_port1", 32'(rd_src[7:4]), 32'd2);
    @(posedge clk);
    #1;
    idle_inputs();
`endif

    // asynchronous reset asserted between clock edges
    @(negedge clk);
    idle_inputs();
    rn_ena = 1; rn_rd = 5; rn_idx = 3;
    cm_ena = 1; cm_rd = 6; cm_idx = 0; cm_val = 32'h42;
    ck_save = 1;
    @(posedge clk);
    #3;
    rd_rs = {5'd6, 5'd5};
    rst_n = 0;
    #1;
    chk("async_rst_src5", 32'(rd_src[3:0]), 32'd0);
    chk("async_rst_val6", rd_val[63:32], 32'd0);
    chk("async_rst_ck_ok", 32'(ck_ok), 32'd0);
    chk("async_rst_empty", 32'(ck_empty), 32'd1);
    chk("async_rst_full", 32'(ck_full), 32'd0);
    chk("async_rst_ck_id", 32'(ck_id), 32'd0);

    do_reset();
    model_reset();
    repeat (600) rand_step();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
